// File: rtl/tape_adc_slicer_if.sv
// Bundle between the resynchronised ADC front end, the slicer and the tape-input mux.
interface tape_adc_slicer_if #(
    parameter int SAMPLE_W = 12
);
    logic [SAMPLE_W-1:0] adc_data;
    logic                adc_sync;
    logic                invert;
    logic                tape_bit;
    logic [SAMPLE_W-1:0] avg;
    logic                primed;
    logic                active;
    logic                edge_stb;
    logic                overrun;

    // Front-end / top-level side: supplies samples and polarity, consumes results.
    modport master (
        output adc_data, adc_sync, invert,
        input  tape_bit, avg, primed, active, edge_stb, overrun
    );

    // Slicer side.
    modport slave (
        input  adc_data, adc_sync, invert,
        output tape_bit, avg, primed, active, edge_stb, overrun
    );
endinterface

// File: rtl/tape_adc_slicer.sv
// Cassette-input slicer: running average over a 2^AVG_LOG2 sample window held in
// block RAM, hysteresis slicing against that average, warm-up gate, edge strobe,
// activity detector and sticky overrun flag. One sample per four clk_sys cycles.
module tape_adc_slicer #(
    parameter int SAMPLE_W    = 12,
    parameter int AVG_LOG2    = 9,
    parameter int HYST        = 100,
    parameter int ACT_SAMPLES = 4800
) (
    input  logic             clk_sys,
    input  logic             RESET,
    tape_adc_slicer_if.slave bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int TOT_W = SAMPLE_W + AVG_LOG2;
    localparam int Q_W   = $clog2(ACT_SAMPLES + 1);

    localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [Q_W-1:0]      Q_MAX     = Q_W'(ACT_SAMPLES);
    localparam logic [SAMPLE_W:0]   HYST_X    = (SAMPLE_W + 1)'(HYST);
    localparam logic [SAMPLE_W:0]   MAX_X     = {1'b0, {SAMPLE_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        UPDATE  = 2'd2,
        COMPARE = 2'd3
    } state_t;

    // Lower threshold, clamped at zero instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_lo(input logic [SAMPLE_W-1:0] a);
        logic [SAMPLE_W:0] ext;
        ext = {1'b0, a};
        if (ext < HYST_X) sat_lo = '0;
        else              sat_lo = SAMPLE_W'(ext - HYST_X);
    endfunction

    // Upper threshold, clamped at full scale instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_hi(input logic [SAMPLE_W-1:0] a);
        logic [SAMPLE_W:0] sum;
        sum = {1'b0, a} + HYST_X;
        if (sum > MAX_X) sat_hi = {SAMPLE_W{1'b1}};
        else             sat_hi = SAMPLE_W'(sum);
    endfunction

    state_t              state_q, state_d;
    logic                sync_q;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic [SAMPLE_W-1:0] rd_q;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic                raw_q, raw_d;
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                primed_q, primed_d;
    logic [Q_W-1:0]      quiet_q, quiet_d;
    logic                edge_q, edge_d;
    logic                overrun_q, overrun_d;
    logic                ram_we, ram_re;
    logic [SAMPLE_W-1:0] old_w, lo_w, hi_w;
    logic                detect;

    logic [SAMPLE_W-1:0] mem [DEPTH];

    assign detect = (bus.adc_sync != sync_q);

    // Window storage: synchronous read, write of the new sample over the oldest one.
    always_ff @(posedge clk_sys) begin
        if (ram_we && !RESET) mem[wr_ptr_q] <= smp_q;
        if (ram_re)           rd_q          <= mem[wr_ptr_q];
    end

    // Sample edge detector; tracks adc_sync during reset so nothing fires right after it.
    always_ff @(posedge clk_sys) begin
        sync_q <= bus.adc_sync;
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath updates for each phase of a sample.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        total_d   = total_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        raw_d     = raw_q;
        avg_d     = avg_q;
        primed_d  = primed_q;
        quiet_d   = quiet_q;
        edge_d    = 1'b0;
        overrun_d = overrun_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        old_w     = '0;
        lo_w      = sat_lo(avg_q);
        hi_w      = sat_hi(avg_q);

        // A new sample while busy is dropped and remembered.
        if (detect && (state_q != IDLE)) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (detect) begin
                    smp_d   = bus.adc_data;
                    state_d = READ;
                end
            end
            READ: begin
                ram_re  = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                // Until the window is full the slot being replaced holds no valid sample.
                if (fill_q == FILL_FULL) old_w = rd_q;
                total_d  = total_q - TOT_W'(old_w) + TOT_W'(smp_q);
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
                state_d  = COMPARE;
            end
            COMPARE: begin
                // Thresholds come from the average before this sample was folded in.
                if (primed_q) begin
                    if (smp_q < lo_w)      raw_d = 1'b1;
                    else if (smp_q > hi_w) raw_d = 1'b0;
                end
                edge_d = (raw_d != raw_q);
                if (edge_d)              quiet_d = '0;
                else if (quiet_q != Q_MAX) quiet_d = quiet_q + 1'b1;
                avg_d    = total_q[TOT_W-1:AVG_LOG2];
                primed_d = (fill_q == FILL_FULL);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator registers, all returned to their idle values by RESET.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            total_q   <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            raw_q     <= 1'b0;
            avg_q     <= '0;
            primed_q  <= 1'b0;
            quiet_q   <= Q_MAX;
            edge_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            total_q   <= total_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            raw_q     <= raw_d;
            avg_q     <= avg_d;
            primed_q  <= primed_d;
            quiet_q   <= quiet_d;
            edge_q    <= edge_d;
            overrun_q <= overrun_d;
        end
    end

    // Captured sample; only meaningful while a sample is in flight, so it is not reset.
    always_ff @(posedge clk_sys) begin
        smp_q <= smp_d;
    end

    assign bus.tape_bit = raw_q ^ bus.invert;
    assign bus.avg      = avg_q;
    assign bus.primed   = primed_q;
    assign bus.active   = (quiet_q < Q_MAX);
    assign bus.edge_stb = edge_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_tape_adc_slicer.sv
// Bench for tape_adc_slicer: directed scenarios plus randomized samples, all
// compared against a window/queue model of the slicer's behaviour.
module tb_tape_adc_slicer;
    localparam int SW    = 12;
    localparam int AL    = 3;
    localparam int HY    = 100;
    localparam int ACT   = 4;
    localparam int DEPTH = 1 << AL;
    localparam int MAXV  = (1 << SW) - 1;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    tape_adc_slicer_if #(.SAMPLE_W(SW)) bus ();

    tape_adc_slicer #(
        .SAMPLE_W(SW), .AVG_LOG2(AL), .HYST(HY), .ACT_SAMPLES(ACT)
    ) dut (
        .clk_sys(clk_sys),
        .RESET  (RESET),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int win[$];
    int m_avg, m_raw, m_quiet, m_edge;
    bit m_primed, m_ovr, m_inv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_avg = 0; m_raw = 0; m_quiet = ACT; m_edge = 0;
        m_primed = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_sample(input int s);
        int lo, hi, prev, sum;
        lo   = (m_avg - HY < 0) ? 0 : m_avg - HY;
        hi   = (m_avg + HY > MAXV) ? MAXV : m_avg + HY;
        prev = m_raw;
        if (m_primed) begin
            if (s < lo)      m_raw = 1;
            else if (s > hi) m_raw = 0;
        end
        m_edge  = (m_raw != prev) ? 1 : 0;
        m_quiet = m_edge ? 0 : ((m_quiet < ACT) ? m_quiet + 1 : ACT);
        win.push_back(s);
        if (win.size() > DEPTH) void'(win.pop_front());
        sum = 0;
        foreach (win[i]) sum += win[i];
        m_avg    = sum / DEPTH;
        m_primed = (win.size() == DEPTH);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".avg"},      32'(bus.avg),      32'(m_avg));
        chk({tag, ".primed"},   32'(bus.primed),   32'(m_primed));
        chk({tag, ".tape_bit"}, 32'(bus.tape_bit), 32'(m_raw[0] ^ m_inv));
        chk({tag, ".edge_stb"}, 32'(bus.edge_stb), 32'(m_edge));
        chk({tag, ".active"},   32'(bus.active),   32'(m_quiet < ACT));
        chk({tag, ".overrun"},  32'(bus.overrun),  32'(m_ovr));
    endtask

    // Present one sample, check results at T+4 and that the strobe is gone at T+5.
    task automatic send(input int v, input string tag);
        @(posedge clk_sys); #1;
        bus.adc_data = SW'(v);
        bus.adc_sync = ~bus.adc_sync;
        model_sample(v);
        repeat (4) @(posedge clk_sys);
        #1;
        check_all(tag);
        @(posedge clk_sys); #1;
        chk({tag, ".stb_drop"}, 32'(bus.edge_stb), 32'd0);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        repeat (n) @(posedge clk_sys);
        #1;
        model_reset();
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v;
        bus.adc_data = '0;
        bus.adc_sync = 1'b0;
        bus.invert   = 1'b0;
        m_inv        = 1'b0;
        model_reset();

        // Reset state while RESET is held for three cycles.
        RESET = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_all("reset");
        RESET = 1'b0;
        bus.invert = 1'b1; m_inv = 1'b1;
        #1;
        chk("invert_comb", 32'(bus.tape_bit), 32'd1);
        bus.invert = 1'b0; m_inv = 1'b0;
        #1;

        // Warm-up with a constant level.
        for (int i = 0; i < DEPTH; i++) begin
            send(2048, "warm");
            chk("warm.primed_dir", 32'(bus.primed), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        chk("warm.avg_dir", 32'(bus.avg), 32'd2048);
        chk("warm.bit_dir", 32'(bus.tape_bit), 32'd0);

        // Slicing across the hysteresis band.
        send(1900, "slice1");
        chk("slice1.bit_dir", 32'(bus.tape_bit), 32'd1);
        chk("slice1.avg_dir", 32'(bus.avg), 32'd2029);
        send(2100, "slice2");
        chk("slice2.bit_dir", 32'(bus.tape_bit), 32'd1);
        send(2200, "slice3");
        chk("slice3.bit_dir", 32'(bus.tape_bit), 32'd0);

        // Activity drops after ACT samples without an edge.
        for (int i = 0; i < ACT; i++) begin
            send(2055, "quiet");
            chk("quiet.active_dir", 32'(bus.active), (i == ACT - 1) ? 32'd0 : 32'd1);
        end

        // Randomized samples around the running average, random polarity.
        for (int i = 0; i < 40; i++) begin
            v = m_avg + int'($urandom_range(0, 600)) - 300;
            if (v < 0) v = 0;
            if (v > MAXV) v = MAXV;
            m_inv = 1'($urandom_range(0, 1));
            bus.invert = m_inv;
            send(v, "rand");
        end
        bus.invert = 1'b0; m_inv = 1'b0;

        // Overrun: second toggle two cycles after the first is dropped.
        do_reset(2);
        @(posedge clk_sys); #1;
        bus.adc_data = SW'(800);
        bus.adc_sync = ~bus.adc_sync;
        model_sample(800);
        repeat (2) @(posedge clk_sys);
        #1;
        bus.adc_data = SW'(4000);
        bus.adc_sync = ~bus.adc_sync;
        m_ovr = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check_all("ovr");
        chk("ovr.avg_dir", 32'(bus.avg), 32'd100);
        chk("ovr.flag_dir", 32'(bus.overrun), 32'd1);
        send(1200, "ovr_next");

        // Lower threshold saturates at zero.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) send(50, "satlo_fill");
        send(0, "satlo");
        chk("satlo.bit_dir", 32'(bus.tape_bit), 32'd0);

        // Upper threshold saturates at full scale.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) send(4050, "sathi_fill");
        send(3900, "sathi_set");
        chk("sathi_set.bit_dir", 32'(bus.tape_bit), 32'd1);
        send(4095, "sathi");
        chk("sathi.bit_dir", 32'(bus.tape_bit), 32'd1);

        // Reset in the middle of a sample, then a fresh warm-up.
        @(posedge clk_sys); #1;
        bus.adc_data = SW'(300);
        bus.adc_sync = ~bus.adc_sync;
        repeat (2) @(posedge clk_sys);
        #1;
        RESET = 1'b1;
        @(posedge clk_sys); #1;
        model_reset();
        check_all("midreset");
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(1000 + 10 * i, "rewarm");
            chk("rewarm.primed_dir", 32'(bus.primed), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        send(800, "rewarm_slice");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tape_adc_slicer.md
# tape_adc_slicer

Parametrised cassette-input slicer that turns raw ADC samples from the `ltc2308` front end into a clean tape bit for the Oric core's `K7_TAPEIN`. It keeps a running average over a power-of-two window in block RAM and slices each sample against that average with symmetric hysteresis. It adds four functions: a warm-up (primed) gate, an optional polarity inversion, an edge strobe with an activity detector, and a sticky overrun flag. It sits between the ADC interface, already resynchronised to `clk_sys`, and the tape-input mux in the top level.

## Interface
Parameters:
- SAMPLE_W, 12, ADC sample width.
- AVG_LOG2, 9, log2 of averaging window depth (DEPTH = 2^AVG_LOG2).
- HYST, 100, hysteresis half-width in LSBs.
- ACT_SAMPLES, 4800, number of samples without an edge before `active` drops.

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- adc_data  in  SAMPLE_W  current ADC sample; stable whenever adc_sync toggles.
- adc_sync  in  1  toggles once per new sample; already in clk_sys domain.
- invert  in  1  1 = invert the output polarity.
- tape_bit  out  1  sliced tape bit, equal to raw_bit ^ invert.
- avg  out  SAMPLE_W  current window average.
- primed  out  1  window has filled; slicing is enabled.
- active  out  1  a raw edge occurred within the last ACT_SAMPLES samples.
- edge_stb  out  1  one-cycle pulse on each raw_bit change.
- overrun  out  1  sticky; a sample arrived while the FSM was busy.

## Operation
- Storage: circular RAM of DEPTH x SAMPLE_W with synchronous read; wr_ptr is AVG_LOG2 bits and wraps naturally.
- Accumulator `total` is SAMPLE_W+AVG_LOG2 bits, unsigned, so it cannot overflow.
- Fill counter is AVG_LOG2+1 bits, saturating at DEPTH.
- Sample detect: `sync_d` registers adc_sync every cycle. A sample is detected when adc_sync != sync_d. During RESET, sync_d <= adc_sync, so no sample is detected in the first cycle after reset.
- FSM states are IDLE → READ → UPDATE → COMPARE → IDLE:
  - IDLE: on detect, latch adc_data into `smp` and go to READ.
  - READ: issue a RAM read at wr_ptr.
  - UPDATE: `old` = RAM data if fill == DEPTH, else 0. Then total <= total - old + smp, write smp at wr_ptr, increment wr_ptr, and increment fill (saturating).
  - COMPARE: compute thresholds from the avg register as it stood before this update. lo = avg - HYST, saturating at 0. hi = avg + HYST, saturating at 2^SAMPLE_W-1. If primed: smp < lo sets raw_bit to 1; smp > hi sets raw_bit to 0; otherwise raw_bit holds. Then avg <= total >> AVG_LOG2 and primed <= (fill == DEPTH).
- The first compare with primed=1 is the sample after the DEPTH-th sample. raw_bit stays 0 before that.
- edge_stb is high for one cycle, on the cycle raw_bit changes.
- Activity: `quiet` counter saturates at ACT_SAMPLES. On a raw edge it goes to 0; on any other compare it increments. active = (quiet < ACT_SAMPLES).
- Overrun: a detect in READ, UPDATE or COMPARE drops that sample, sets overrun (cleared only by RESET) and updates sync_d as normal.
- Reset values: tape_bit = invert (raw_bit = 0), avg 0, primed 0, active 0 (quiet = ACT_SAMPLES), edge_stb 0, overrun 0, total 0, fill 0, wr_ptr 0, FSM IDLE. RAM contents are not cleared; the fill gating makes them irrelevant.
- RESET mid-operation: the current sample is abandoned and the block returns to the reset state on the next clock.

## Timing
- Detect cycle T is IDLE. READ is T+1, UPDATE T+2, COMPARE T+3. avg, primed, raw_bit, edge_stb and active are visible from T+4.
- Minimum sample spacing is 4 cycles. A detect at T+1..T+3 counts as an overrun.
- tape_bit is combinational from raw_bit and invert, with 0-cycle response to `invert`.
- Throughput is one sample per 4 clk_sys cycles. The 48 kHz ADC rate at 50 MHz leaves ample margin.

## Test plan
- Reset: hold RESET 3 cycles with invert=0 → tape_bit 0, avg 0, primed 0, active 0, edge_stb 0, overrun 0. Setting invert=1 → tape_bit 1 immediately.
- Warm-up (AVG_LOG2=3): 8 samples of 2048, spaced 10 cycles → primed=1 and avg=2048 at T+4 of the 8th sample; tape_bit 0; no edge_stb.
- Slicing (continuing): sample 1900 (lo 1948) → raw_bit 1, edge_stb pulse at T+4, avg 2029. Sample 2100 (hi 2129) → hold 1. Sample 2200 (avg 2036, hi 2136) → raw_bit 0 with a second edge_stb.
- Saturation: primed window with avg 50, HYST 100; sample 0 → lo saturates at 0, no change. Avg 4050, sample 4095 → hi saturates at 4095, no change.
- Activity and overrun (ACT_SAMPLES=4): after an edge, active=1. Four samples without an edge → active 0 at T+4 of the 4th. Two toggles 2 cycles apart → overrun=1, fill/total reflect one sample only.
- Reset mid-op: assert RESET at T+2 → next cycle all state at reset values. The following sample starts a fresh warm-up (primed 0 until 8 more samples).
